// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM burst staging cache: default geometry and FSM state types.
package sdram_pkg;

  localparam int unsigned BURST_POW = 3;
  localparam int unsigned CACHE_POW = 3;
  localparam int unsigned BL        = 1 << BURST_POW;
  localparam int unsigned NSLOT     = 1 << CACHE_POW;
  localparam int unsigned DEPTH     = NSLOT * BL;
  localparam int unsigned WPTR_W    = CACHE_POW + BURST_POW + 1;
  localparam int unsigned RSLOT_W   = CACHE_POW + 1;

  typedef enum logic {RD_IDLE, RD_BURST} rd_state_e;
  typedef enum logic {FL_IDLE, FL_PAD}   fl_state_e;

endpackage

// File: rtl/sdram_cache_ram.sv
// Simple dual-port word store with synchronous write and registered read; array is not reset.
module sdram_cache_ram
  import sdram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sdram_burst_cache.sv
// Burst-granular staging cache: word-serial writes into a ring of burst slots,
// complete slots drained as gap-free bursts, with partial-burst flush padding.
module sdram_burst_cache
  import sdram_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH     = 16,
  parameter int unsigned          BURST_POW_SIZE = 3,
  parameter int unsigned          CACHE_POW_SIZE = 3,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE     = '0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wr,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_flush,
  output logic                    o_full,
  output logic                    o_busy,
  output logic                    o_ovf,
  output logic                    o_burst_rdy,
  output logic [CACHE_POW_SIZE:0] o_bursts,
  input  logic                    i_rd_start,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_rd_last
);

  localparam int unsigned ADDR_W = CACHE_POW_SIZE + BURST_POW_SIZE;
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned SLOT_W = CACHE_POW_SIZE + 1;

  logic [PTR_W-1:0]          wptr_q, wptr_d, occ_d;
  logic [SLOT_W-1:0]         rslot_q, rslot_d;
  logic [BURST_POW_SIZE-1:0] rcnt_q, rcnt_d, rcnt_nxt;
  rd_state_e                 rd_state_q, rd_state_d;
  fl_state_e                 fl_state_q, fl_state_d;
  logic                      full_q, full_d, ovf_q, ovf_d;
  logic                      busy, wr_ok, burst_rdy;
  logic [SLOT_W-1:0]         bursts;
  logic                      ram_we, ram_re;
  logic [ADDR_W-1:0]         ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0]     ram_wdata, ram_rdata;

  assign busy      = (fl_state_q == FL_PAD);
  assign wr_ok     = i_wr && !full_q && !busy;
  assign bursts    = wptr_q[PTR_W-1:BURST_POW_SIZE] - rslot_q;
  assign burst_rdy = (bursts != '0) && (rd_state_q == RD_IDLE);
  assign rcnt_nxt  = rcnt_q + 1'b1;

  // Write side and flush FSM; the alignment test uses the post-write pointer so a
  // write arriving with i_flush lands first and padding completes from there.
  always_comb begin
    ram_we     = 1'b0;
    ram_wdata  = i_data;
    ram_waddr  = wptr_q[ADDR_W-1:0];
    wptr_d     = wptr_q;
    fl_state_d = fl_state_q;
    ovf_d      = ovf_q | (i_wr & ~wr_ok);
    if (busy) begin
      ram_we    = 1'b1;
      ram_wdata = PAD_VALUE;
      wptr_d    = wptr_q + 1'b1;
    end else if (wr_ok) begin
      ram_we = 1'b1;
      wptr_d = wptr_q + 1'b1;
    end
    case (fl_state_q)
      FL_IDLE: if (i_flush && (wptr_d[BURST_POW_SIZE-1:0] != '0)) fl_state_d = FL_PAD;
      FL_PAD:  if (wptr_d[BURST_POW_SIZE-1:0] == '0) fl_state_d = FL_IDLE;
      default: fl_state_d = FL_IDLE;
    endcase
  end

  // Reader FSM: word k's address is issued one cycle ahead of its output so the
  // registered RAM read yields valid data on the cycle right after i_rd_start.
  always_comb begin
    rd_state_d = rd_state_q;
    rcnt_d     = rcnt_q;
    rslot_d    = rslot_q;
    ram_re     = 1'b0;
    ram_raddr  = {rslot_q[CACHE_POW_SIZE-1:0], rcnt_nxt};
    case (rd_state_q)
      RD_IDLE: begin
        if (i_rd_start && burst_rdy) begin
          rd_state_d = RD_BURST;
          rcnt_d     = '0;
          ram_re     = 1'b1;
          ram_raddr  = {rslot_q[CACHE_POW_SIZE-1:0], {BURST_POW_SIZE{1'b0}}};
        end
      end
      RD_BURST: begin
        ram_re = (rcnt_q != '1);
        rcnt_d = rcnt_nxt;
        if (rcnt_q == '1) begin
          rd_state_d = RD_IDLE;
          rslot_d    = rslot_q + 1'b1;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    occ_d  = wptr_d - {rslot_d, {BURST_POW_SIZE{1'b0}}};
    full_d = (occ_d == {1'b1, {ADDR_W{1'b0}}});
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q     <= '0;
      rslot_q    <= '0;
      rcnt_q     <= '0;
      rd_state_q <= RD_IDLE;
      fl_state_q <= FL_IDLE;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rslot_q    <= rslot_d;
      rcnt_q     <= rcnt_d;
      rd_state_q <= rd_state_d;
      fl_state_q <= fl_state_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
    end
  end

  sdram_cache_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_W)
  ) u_ram (
    .clk  (i_clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign o_full      = full_q;
  assign o_busy      = busy;
  assign o_ovf       = ovf_q;
  assign o_burst_rdy = burst_rdy;
  assign o_bursts    = bursts;
  assign o_rd_valid  = (rd_state_q == RD_BURST);
  assign o_rd_last   = o_rd_valid && (rcnt_q == '1);
  assign o_rd_data   = o_rd_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_sdram_burst_cache.sv
// Scoreboard bench for sdram_burst_cache: directed stimulus queues expected burst beats,
// an independent monitor compares every valid read beat.
module tb_sdram_burst_cache;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_wr = 1'b0;
  logic [15:0] i_data = '0;
  logic        i_flush = 1'b0;
  logic        i_rd_start = 1'b0;
  logic        o_full, o_busy, o_ovf, o_burst_rdy, o_rd_valid, o_rd_last;
  logic [3:0]  o_bursts;
  logic [15:0] o_rd_data;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;
  logic        mid_burst = 1'b0;

  sdram_burst_cache #(
    .DATA_WIDTH(16),
    .BURST_POW_SIZE(3),
    .CACHE_POW_SIZE(3),
    .PAD_VALUE(16'h0000)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr(i_wr), .i_data(i_data), .i_flush(i_flush),
    .o_full(o_full), .o_busy(o_busy), .o_ovf(o_ovf), .o_burst_rdy(o_burst_rdy),
    .o_bursts(o_bursts), .i_rd_start(i_rd_start), .o_rd_data(o_rd_data),
    .o_rd_valid(o_rd_valid), .o_rd_last(o_rd_last)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: pops one expected beat per valid output cycle and flags gaps inside a burst.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      mid_burst = 1'b0;
    end else if (o_rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", {31'b0, o_rd_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_data", {16'b0, o_rd_data}, {16'b0, mon_e.d});
        chk("rd_last", {31'b0, o_rd_last}, {31'b0, mon_e.l});
      end
      mid_burst = !o_rd_last;
    end else if (mid_burst) begin
      chk("rd_gap", {31'b0, o_rd_valid}, 32'd1);
      mid_burst = 1'b0;
    end
  end

  task automatic push_burst(input int base);
    for (int k = 0; k < 8; k++) exp_q.push_back('{d: 16'(base + k), l: (k == 7)});
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_wr = 1'b0; i_flush = 1'b0; i_rd_start = 1'b0;
    repeat (2) @(negedge i_clk);
    exp_q.delete();
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic write_words(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      i_wr = 1'b1; i_data = 16'(base + k);
    end
    @(negedge i_clk);
    i_wr = 1'b0;
  endtask

  task automatic read_burst();
    int cnt;
    chk("burst_rdy_before", {31'b0, o_burst_rdy}, 32'd1);
    i_rd_start = 1'b1;
    @(negedge i_clk);
    i_rd_start = 1'b0;
    chk("burst_rdy_during", {31'b0, o_burst_rdy}, 32'd0);
    cnt = 0;
    while ((exp_q.size() != 0 || o_rd_valid) && cnt < 20) begin
      @(negedge i_clk);
      cnt++;
    end
    if (cnt >= 20) chk("rd_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_full"},  {31'b0, o_full},      32'd0);
    chk({tag, "_busy"},  {31'b0, o_busy},      32'd0);
    chk({tag, "_ovf"},   {31'b0, o_ovf},       32'd0);
    chk({tag, "_rdy"},   {31'b0, o_burst_rdy}, 32'd0);
    chk({tag, "_bursts"},{28'b0, o_bursts},    32'd0);
    chk({tag, "_valid"}, {31'b0, o_rd_valid},  32'd0);
    chk({tag, "_last"},  {31'b0, o_rd_last},   32'd0);
    chk({tag, "_data"},  {16'b0, o_rd_data},   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, to, busy_cnt;
    #1 chk_all_zero("rst");

    // Single burst
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      @(negedge i_clk);
      if (k == 8) chk("bursts_pre8", {28'b0, o_bursts}, 32'd0);
      i_wr = 1'b1; i_data = 16'(k);
    end
    @(negedge i_clk);
    i_wr = 1'b0;
    chk("bursts_after8", {28'b0, o_bursts}, 32'd1);
    push_burst(1);
    read_burst();
    chk("bursts_drained", {28'b0, o_bursts}, 32'd0);

    // Fill and overflow
    do_reset();
    for (int k = 0; k < 64; k++) begin
      @(negedge i_clk);
      if (k == 63) chk("full_at63", {31'b0, o_full}, 32'd0);
      i_wr = 1'b1; i_data = 16'(16'h100 + k);
    end
    @(negedge i_clk);
    i_data = 16'h1FF;
    chk("full_at64", {31'b0, o_full}, 32'd1);
    chk("bursts_at64", {28'b0, o_bursts}, 32'd8);
    chk("ovf_before65", {31'b0, o_ovf}, 32'd0);
    @(negedge i_clk);
    i_wr = 1'b0;
    chk("ovf_after65", {31'b0, o_ovf}, 32'd1);
    chk("full_after65", {31'b0, o_full}, 32'd1);

    // Release while full, writing continuously
    push_burst(16'h100);
    i_rd_start = 1'b1; i_wr = 1'b1; i_data = 16'h1FF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge i_clk);
      i_rd_start = 1'b0;
      chk("full_hold", {31'b0, o_full}, 32'd1);
    end
    @(negedge i_clk);
    chk("full_released", {31'b0, o_full}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      if (k != 0) @(negedge i_clk);
      i_data = 16'(16'h200 + k);
    end
    @(negedge i_clk);
    i_wr = 1'b0;
    chk("full_again", {31'b0, o_full}, 32'd1);
    for (int b = 0; b < 7; b++) begin
      push_burst(16'h108 + 8 * b);
      read_burst();
    end
    push_burst(16'h200);
    read_burst();
    chk("empty_after_full", {28'b0, o_bursts}, 32'd0);

    // Flush with padding
    do_reset();
    write_words(16'hA1, 3);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    chk("busy_rise", {31'b0, o_busy}, 32'd1);
    busy_cnt = 0;
    to = 0;
    while (o_busy && to < 20) begin
      busy_cnt++;
      i_wr = (busy_cnt == 1); i_data = 16'hEE;
      @(negedge i_clk);
      to++;
    end
    i_wr = 1'b0;
    chk("busy_len", busy_cnt, 32'd5);
    chk("flush_ovf", {31'b0, o_ovf}, 32'd1);
    chk("flush_bursts", {28'b0, o_bursts}, 32'd1);
    exp_q.push_back('{d: 16'hA1, l: 1'b0});
    exp_q.push_back('{d: 16'hA2, l: 1'b0});
    exp_q.push_back('{d: 16'hA3, l: 1'b0});
    for (int k = 0; k < 5; k++) exp_q.push_back('{d: 16'h0000, l: (k == 4)});
    read_burst();

    // Wrap-around
    do_reset();
    for (int it = 0; it < 20; it++) begin
      write_words(16'h1000 + 8 * it, 8);
      push_burst(16'h1000 + 8 * it);
      read_burst();
    end
    chk("wrap_ovf", {31'b0, o_ovf}, 32'd0);
    chk("wrap_bursts", {28'b0, o_bursts}, 32'd0);

    // Reset in the middle of a burst
    write_words(16'h300, 8);
    push_burst(16'h300);
    i_rd_start = 1'b1;
    @(negedge i_clk);
    i_rd_start = 1'b0;
    nv = 0;
    to = 0;
    while (to < 20) begin
      if (o_rd_valid) nv++;
      if (nv == 4) break;
      @(negedge i_clk);
      to++;
    end
    chk("mid_burst_reached", nv, 32'd4);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_valid_drop", {31'b0, o_rd_valid}, 32'd0);
    chk("rst_data_drop", {16'b0, o_rd_data}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk_all_zero("post_rst");
    write_words(16'h400, 8);
    push_burst(16'h400);
    read_burst();
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
